pe_alu_switch_slice: RTL and testbench



---
 rtl/pe_alu_switch_slice.sv | 114 +++++++++++
 tb/tb_pe_alu_switch_slice.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pe_alu_switch_slice.sv
// CGRA processing-element slice: a 4x4 input crossbar feeding a registered
// two-operand ALU, plus a 2:1 output selector. All routing and the opcode
// come from a 13-bit serial configuration chain that can be daisy-chained.
module pe_alu_switch_slice #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            config_en,
    input  logic            config_in,
    output logic            config_out,
    input  logic [size-1:0] in0,
    input  logic [size-1:0] in1,
    input  logic [size-1:0] aux_in,
    output logic [size-1:0] out0,
    output logic [size-1:0] route_out2,
    output logic [size-1:0] route_out3
);

    localparam int sh_w = $clog2(size);

    // Configuration layout: {alu_op[3:0], out_sel, xbar_sel3..xbar_sel0}
    logic [12:0]     cfg_reg;
    logic [size-1:0] alu_q;
    logic [size-1:0] alu_next;
    logic [3:0]      alu_op;
    logic            out_sel;
    logic [size-1:0] xbar_out [4];

    assign alu_op     = cfg_reg[12:9];
    assign out_sel    = cfg_reg[8];
    assign config_out = cfg_reg[0];

    // Serial configuration chain, new bits enter at the MSB end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_reg <= '0;
        end else if (config_en) begin
            cfg_reg <= {config_in, cfg_reg[12:1]};
        end
    end

    // Crossbar: each output picks in0 / in1 / registered ALU result / aux_in.
    // Source 2 is the register, so the ALU feedback loop is broken by a flop.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_xbar
            logic [1:0] sel;
            assign sel = cfg_reg[2*gi+1:2*gi];

            // Per-output 4:1 source select
            always_comb begin
                case (sel)
                    2'd0:    xbar_out[gi] = in0;
                    2'd1:    xbar_out[gi] = in1;
                    2'd2:    xbar_out[gi] = alu_q;
                    default: xbar_out[gi] = aux_in;
                endcase
            end
        end
    endgenerate

    assign route_out2 = xbar_out[2];
    assign route_out3 = xbar_out[3];

    logic [size-1:0]        op_a;
    logic [size-1:0]        op_b;
    logic signed [size-1:0] op_a_s;
    logic signed [size-1:0] op_b_s;
    logic [sh_w-1:0]        sh;

    assign op_a   = xbar_out[0];
    assign op_b   = xbar_out[1];
    assign op_a_s = op_a;
    assign op_b_s = op_b;
    assign sh     = op_b[sh_w-1:0];

    // ALU function; all results truncated to the datapath width
    always_comb begin
        alu_next = '0;
        case (alu_op)
            4'd0:  alu_next = op_a + op_b;
            4'd1:  alu_next = op_a - op_b;
            4'd2:  alu_next = op_a * op_b;
            4'd3:  alu_next = op_a & op_b;
            4'd4:  alu_next = op_a | op_b;
            4'd5:  alu_next = op_a ^ op_b;
            4'd6:  alu_next = op_a << sh;
            4'd7:  alu_next = op_a >> sh;
            4'd8:  alu_next = op_a_s >>> sh;
            4'd9:  alu_next = {{(size-1){1'b0}}, op_a == op_b};
            4'd10: alu_next = {{(size-1){1'b0}}, op_a != op_b};
            4'd11: alu_next = {{(size-1){1'b0}}, op_a_s < op_b_s};
            4'd12: alu_next = {{(size-1){1'b0}}, op_a < op_b};
            4'd13: alu_next = (op_a_s < op_b_s) ? op_a : op_b;
            4'd14: alu_next = (op_a_s < op_b_s) ? op_b : op_a;
            default: alu_next = op_a;
        endcase
    end

    // ALU result register; frozen while the configuration chain is shifting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_q <= '0;
        end else if (!config_en) begin
            alu_q <= alu_next;
        end
    end

    // Output selector: registered ALU result or memory result passthrough
    always_comb begin
        out0 = out_sel ? aux_in : alu_q;
    end

endmodule

// File: tb/tb_pe_alu_switch_slice.sv
// Directed bench for pe_alu_switch_slice: reset defaults, configuration
// shift-through, every ALU opcode, accumulator feedback, routing and
// asynchronous reset during operation.
module tb_pe_alu_switch_slice;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        config_en = 1'b0;
    logic        config_in = 1'b0;
    logic        config_out;
    logic [31:0] in0 = '0;
    logic [31:0] in1 = '0;
    logic [31:0] aux_in = '0;
    logic [31:0] out0;
    logic [31:0] route_out2;
    logic [31:0] route_out3;

    int checks = 0;
    int errors = 0;

    pe_alu_switch_slice #(.size(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .config_en  (config_en),
        .config_in  (config_in),
        .config_out (config_out),
        .in0        (in0),
        .in1        (in1),
        .aux_in     (aux_in),
        .out0       (out0),
        .route_out2 (route_out2),
        .route_out3 (route_out3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Shift a 13-bit word in, LSB first; leaves config_en low afterwards
    task automatic load_cfg(input logic [12:0] v);
        for (int i = 0; i < 13; i++) begin
            config_en = 1'b1;
            config_in = v[i];
            @(posedge clk);
            #1;
        end
        config_en = 1'b0;
        config_in = 1'b0;
    endtask

    function automatic logic [12:0] mk(input logic [3:0] op, input logic sel,
                                       input logic [1:0] x3, input logic [1:0] x2,
                                       input logic [1:0] x1, input logic [1:0] x0);
        return {op, sel, x3, x2, x1, x0};
    endfunction

    logic [12:0] v;
    logic [31:0] exp_tab [16];

    initial begin
        // ---------------- reset default ----------------
        in0 = 32'd5;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out0", out0, 32'd0);
        check("rst_cfgout", {31'd0, config_out}, 32'd0);
        check("rst_route2", route_out2, 32'd5);
        check("rst_route3", route_out3, 32'd5);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("dflt_out0", out0, 32'd10);

        // ---------------- configuration shift-through ----------------
        v = 13'h1ABC;
        aux_in = 32'hCAFE_0001;
        load_cfg(v);
        // 0x1ABC -> xbar2 = 3, so route_out2 follows aux_in
        check("cfg_route2", route_out2, 32'hCAFE_0001);
        for (int i = 0; i < 13; i++) begin
            check($sformatf("cfg_bit%0d", i), {31'd0, config_out}, {31'd0, v[i]});
            config_en = 1'b1;
            config_in = 1'b0;
            @(posedge clk);
            #1;
        end
        config_en = 1'b0;
        check("cfg_empty", {31'd0, config_out}, 32'd0);

        // ---------------- every ALU opcode ----------------
        in0 = 32'hFFFF_FFFE;
        in1 = 32'd3;
        exp_tab[0]  = 32'h0000_0001;
        exp_tab[1]  = 32'hFFFF_FFFB;
        exp_tab[2]  = 32'hFFFF_FFFA;
        exp_tab[3]  = 32'h0000_0002;
        exp_tab[4]  = 32'hFFFF_FFFF;
        exp_tab[5]  = 32'hFFFF_FFFD;
        exp_tab[6]  = 32'hFFFF_FFF0;
        exp_tab[7]  = 32'h1FFF_FFFF;
        exp_tab[8]  = 32'hFFFF_FFFF;
        exp_tab[9]  = 32'h0000_0000;
        exp_tab[10] = 32'h0000_0001;
        exp_tab[11] = 32'h0000_0001;
        exp_tab[12] = 32'h0000_0000;
        exp_tab[13] = 32'hFFFF_FFFE;
        exp_tab[14] = 32'h0000_0003;
        exp_tab[15] = 32'hFFFF_FFFE;
        for (int op = 0; op < 16; op++) begin
            load_cfg(mk(op[3:0], 1'b0, 2'd0, 2'd0, 2'd1, 2'd0));
            @(posedge clk);
            #1;
            check($sformatf("alu_op%0d", op), out0, exp_tab[op]);
        end
        // Shift amount uses only the low log2(size) bits of b
        in1 = 32'h0000_0023;
        load_cfg(mk(4'd6, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0));
        @(posedge clk);
        #1;
        check("shl_mask", out0, 32'hFFFF_FFF0);
        // Equal operands
        in0 = 32'h8000_0000;
        in1 = 32'h8000_0000;
        load_cfg(mk(4'd9, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0));
        @(posedge clk);
        #1;
        check("eq_true", out0, 32'd1);
        // Add wraps modulo 2^32
        load_cfg(mk(4'd0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0));
        @(posedge clk);
        #1;
        check("add_wrap", out0, 32'd0);

        // ---------------- accumulator feedback ----------------
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        in1 = 32'd7;
        load_cfg(mk(4'd0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd2));
        check("acc_0", out0, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("acc_%0d", k), out0, 32'(7 * k));
        end

        // ---------------- async reset mid-operation ----------------
        in0 = 32'd5;
        #3;
        reset = 1'b0;
        #1;
        check("arst_out0", out0, 32'd0);
        check("arst_route2", route_out2, 32'd5);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("arst_dflt1", out0, 32'd10);
        @(posedge clk);
        #1;
        check("arst_dflt2", out0, 32'd10);

        // ---------------- routing ----------------
        load_cfg(mk(4'd0, 1'b1, 2'd1, 2'd3, 2'd0, 2'd0));
        aux_in = 32'hDEAD_BEEF;
        in1 = 32'h0000_1234;
        #1;
        check("rt_out0", out0, 32'hDEAD_BEEF);
        check("rt_route2", route_out2, 32'hDEAD_BEEF);
        check("rt_route3", route_out3, 32'h0000_1234);
        aux_in = 32'h0BAD_F00D;
        in1 = 32'h0000_5678;
        #1;
        check("rt_out0_b", out0, 32'h0BAD_F00D);
        check("rt_route3_b", route_out3, 32'h0000_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
